// File: rtl/seg_link_pkg.sv
// Shared definitions for the serial 7-segment display link: frame size,
// active-low segment patterns and the pattern-to-hex decode helper.
package seg_link_pkg;

    localparam int FRAME_BITS = 8;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef struct packed {
        logic       valid;
        logic       blank;
        logic [3:0] hex;
    } seg_dec_t;

    // Unknown patterns come back as an invalid 'E' so the display shows an error glyph
    function automatic seg_dec_t seg_to_hex(input logic [6:0] seg);
        seg_dec_t r;
        r.valid = 1'b1;
        r.blank = 1'b0;
        r.hex   = 4'hE;
        case (seg)
            SEG_0:     r.hex = 4'h0;
            SEG_1:     r.hex = 4'h1;
            SEG_2:     r.hex = 4'h2;
            SEG_3:     r.hex = 4'h3;
            SEG_4:     r.hex = 4'h4;
            SEG_5:     r.hex = 4'h5;
            SEG_6:     r.hex = 4'h6;
            SEG_7:     r.hex = 4'h7;
            SEG_8:     r.hex = 4'h8;
            SEG_9:     r.hex = 4'h9;
            SEG_BLANK: begin
                r.blank = 1'b1;
                r.hex   = 4'hF;
            end
            default:   r.valid = 1'b0;
        endcase
        return r;
    endfunction

    // Position index of a one-hot digit select (callers guarantee one-hot)
    function automatic logic [1:0] onehot_to_idx(input logic [3:0] sel);
        logic [1:0] idx;
        case (sel)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seg_serial_receiver_if.sv
// Serial 7-segment link plus the decoded display view seen by the receiver.
// The master drives the link (LED driver or bench), the slave is the receiver.
interface seg_serial_receiver_if;

    logic        ser_clk;
    logic        ser_data;
    logic [3:0]  dig_sel;

    logic [15:0] digit;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        frame_valid;
    logic [1:0]  frame_idx;
    logic        frame_err;
    logic        scan_done;

    modport master (
        output ser_clk, ser_data, dig_sel,
        input  digit, dp, blank, frame_valid, frame_idx, frame_err, scan_done
    );

    modport slave (
        input  ser_clk, ser_data, dig_sel,
        output digit, dp, blank, frame_valid, frame_idx, frame_err, scan_done
    );

endinterface

// File: rtl/seg_sync_edge.sv
// N-stage synchronizer with a registered "leaves zero" pulse: rise_o fires for
// one cycle when the synced value goes from all-zero to anything nonzero.
module seg_sync_edge #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] level_o,
    output logic             rise_o
);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] prev_q;
    logic             rise_q;

    // Synchronizer chain, previous-value register and registered edge pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
            rise_q <= 1'b0;
        end else begin
            sync_q[0] <= async_i;
            for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_q[STAGES-1];
            rise_q <= (|sync_q[STAGES-1]) & ~(|prev_q);
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = rise_q;

endmodule

// File: rtl/seg_serial_receiver.sv
// Display-end deserializer for the serial 7-segment link: collects MSB-first
// frames, decodes them on a digit latch and keeps a per-position display image.
module seg_serial_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg_serial_receiver_if.slave link
);
    import seg_link_pkg::*;

    localparam int               CNT_W    = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    logic                  clkRise;
    logic                  serClkLevel_unused;
    logic                  latchEvent;
    logic [3:0]            digSel;
    logic [SYNC_STAGES-1:0] dataSync_q;
    logic                  serData;

    logic [FRAME_BITS-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]      bitCount_q, bitCount_d;
    logic [15:0]           digit_q, digit_d;
    logic [3:0]            dp_q, dp_d;
    logic [3:0]            blank_q, blank_d;
    logic                  frameValid_q, frameValid_d;
    logic [1:0]            frameIdx_q, frameIdx_d;
    logic                  frameErr_q, frameErr_d;
    logic [3:0]            scanMask_q, scanMask_d;
    logic                  scanDone_q, scanDone_d;

    seg_dec_t              dec;
    logic [1:0]            idx;
    logic                  frameOk;

    seg_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_clkSync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (link.ser_clk),
        .level_o (serClkLevel_unused),
        .rise_o  (clkRise)
    );

    seg_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(4)) u_selSync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (link.dig_sel),
        .level_o (digSel),
        .rise_o  (latchEvent)
    );

    // Plain synchronizer for the data line; it only needs to be stable around the clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dataSync_q <= '0;
        else        dataSync_q <= {dataSync_q[SYNC_STAGES-2:0], link.ser_data};
    end
    assign serData = dataSync_q[SYNC_STAGES-1];

    // Next-state: latch beats shift, a good frame updates one position, scan mask tracks coverage
    always_comb begin
        dec          = seg_to_hex(sreg_q[6:0]);
        idx          = onehot_to_idx(digSel);
        frameOk      = latchEvent && (bitCount_q == CNT_FULL) && $onehot(digSel);

        sreg_d       = sreg_q;
        bitCount_d   = bitCount_q;
        digit_d      = digit_q;
        dp_d         = dp_q;
        blank_d      = blank_q;
        frameIdx_d   = frameIdx_q;
        frameValid_d = 1'b0;
        frameErr_d   = 1'b0;

        if (latchEvent) begin
            bitCount_d = '0;
            if (frameOk) begin
                frameValid_d              = 1'b1;
                frameErr_d                = ~dec.valid;
                frameIdx_d                = idx;
                digit_d[{idx, 2'b00} +: 4] = dec.hex;
                dp_d[idx]                 = ~sreg_q[FRAME_BITS-1];
                blank_d[idx]              = dec.blank;
            end else begin
                frameErr_d = 1'b1;
            end
        end else if (clkRise && (digSel == 4'b0000)) begin
            sreg_d = {sreg_q[FRAME_BITS-2:0], serData};
            if (bitCount_q != CNT_SAT) bitCount_d = bitCount_q + CNT_W'(1);
        end

        scanDone_d = (scanMask_q == 4'hF);
        scanMask_d = (scanMask_q == 4'hF) ? 4'h0 : scanMask_q;
        if (frameOk) scanMask_d = scanMask_d | digSel;
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q       <= '1;
            bitCount_q   <= '0;
            digit_q      <= 16'hFFFF;
            dp_q         <= 4'h0;
            blank_q      <= 4'hF;
            frameValid_q <= 1'b0;
            frameIdx_q   <= 2'd0;
            frameErr_q   <= 1'b0;
            scanMask_q   <= 4'h0;
            scanDone_q   <= 1'b0;
        end else begin
            sreg_q       <= sreg_d;
            bitCount_q   <= bitCount_d;
            digit_q      <= digit_d;
            dp_q         <= dp_d;
            blank_q      <= blank_d;
            frameValid_q <= frameValid_d;
            frameIdx_q   <= frameIdx_d;
            frameErr_q   <= frameErr_d;
            scanMask_q   <= scanMask_d;
            scanDone_q   <= scanDone_d;
        end
    end

    assign link.digit       = digit_q;
    assign link.dp          = dp_q;
    assign link.blank       = blank_q;
    assign link.frame_valid = frameValid_q;
    assign link.frame_idx   = frameIdx_q;
    assign link.frame_err   = frameErr_q;
    assign link.scan_done   = scanDone_q;

endmodule

// File: tb/tb_seg_serial_receiver.sv
// Scoreboard bench for seg_serial_receiver: a behavioural display model queues
// the expected response of every latch, a negedge monitor pops and compares.
module tb_seg_serial_receiver;

    localparam int SYNC_STAGES = 2;

    typedef struct {
        bit        fv;
        bit        fe;
        bit [1:0]  idx;
        bit [15:0] digit;
        bit [3:0]  dp;
        bit [3:0]  blank;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    seg_serial_receiver_if link();

    seg_serial_receiver #(.SYNC_STAGES(SYNC_STAGES), .FRAME_BITS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .link  (link)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;
    int lastValidCycle = -100;
    int scanSeen   = 0;

    exp_t expQ[$];
    bit   scanQ[$];
    exp_t monE;

    bit [6:0]  segTable[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Display model: what a human reading the LEDs would see
    bit [15:0] mDigit;
    bit [3:0]  mDp;
    bit [3:0]  mBlank;
    bit [1:0]  mIdx;
    bit [3:0]  mMask;
    bit        mBits[$];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void refDecode(input bit [6:0] seg, output bit [3:0] hex,
                                      output bit blankF, output bit bad);
        hex = 4'hE; blankF = 1'b0; bad = 1'b1;
        if (seg == 7'h7F) begin
            hex = 4'hF; blankF = 1'b1; bad = 1'b0;
        end
        for (int d = 0; d < 10; d++)
            if (segTable[d] == seg) begin
                hex = 4'(d); bad = 1'b0;
            end
    endfunction

    task automatic shiftBit(input bit b);
        link.ser_data = b;
        tick(3);
        link.ser_clk = 1'b1;
        tick(4);
        link.ser_clk = 1'b0;
        tick(3);
        mBits.push_back(b);
    endtask

    task automatic latchFrame(input bit [3:0] sel);
        exp_t     e;
        bit [7:0] frame;
        bit [3:0] hex;
        bit       bl, bad;
        int       pos, lat;
        if (mBits.size() == 8 && $countones(sel) == 1) begin
            for (int i = 0; i < 8; i++) frame[7-i] = mBits[i];
            pos = 0;
            for (int p = 0; p < 4; p++) if (sel[p]) pos = p;
            refDecode(frame[6:0], hex, bl, bad);
            mDigit[pos*4 +: 4] = hex;
            mDp[pos]    = ~frame[7];
            mBlank[pos] = bl;
            mIdx        = 2'(pos);
            e.fv = 1'b1;
            e.fe = bad;
            mMask = mMask | sel;
            if (mMask == 4'hF) begin
                scanQ.push_back(1'b1);
                mMask = 4'h0;
            end
        end else begin
            e.fv = 1'b0;
            e.fe = 1'b1;
        end
        e.idx = mIdx; e.digit = mDigit; e.dp = mDp; e.blank = mBlank;
        expQ.push_back(e);
        mBits.delete();

        link.dig_sel = sel;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            tick(1);
            if (link.frame_valid === 1'b1 || link.frame_err === 1'b1) begin
                lat = c;
                break;
            end
        end
        checkOutput("latch_latency", lat, SYNC_STAGES + 2);
        tick(2);
        link.dig_sel = 4'b0000;
        tick(5);
    endtask

    task automatic applyStimulus(input bit [7:0] value, input int nbits, input bit [3:0] sel);
        for (int i = nbits - 1; i >= 0; i--)
            shiftBit(i < 8 ? value[i] : 1'b0);
        latchFrame(sel);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        tick(2);
        mDigit = 16'hFFFF; mDp = 4'h0; mBlank = 4'hF; mIdx = 2'd0; mMask = 4'h0;
        mBits.delete();
        checkOutput("reset_digit", link.digit, 16'hFFFF);
        checkOutput("reset_dp", link.dp, 4'h0);
        checkOutput("reset_blank", link.blank, 4'hF);
        checkOutput("reset_frame_valid", link.frame_valid, 1'b0);
        checkOutput("reset_frame_err", link.frame_err, 1'b0);
        checkOutput("reset_frame_idx", link.frame_idx, 2'd0);
        checkOutput("reset_scan_done", link.scan_done, 1'b0);
        rst_n = 1'b1;
        tick(4);
    endtask

    always @(posedge clk) cycle++;

    // Monitor: every frame_valid / frame_err / scan_done must match a queued expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (link.frame_valid === 1'b1 || link.frame_err === 1'b1) begin
                if (expQ.size() == 0) begin
                    compared++; mismatched++;
                    $display("[TB] FAIL unexpected_frame: got valid=%b err=%b, expected no response",
                             link.frame_valid, link.frame_err);
                end else begin
                    monE = expQ.pop_front();
                    checkOutput("frame_valid", link.frame_valid, monE.fv);
                    checkOutput("frame_err", link.frame_err, monE.fe);
                    checkOutput("frame_idx", link.frame_idx, monE.idx);
                    checkOutput("digit", link.digit, monE.digit);
                    checkOutput("dp", link.dp, monE.dp);
                    checkOutput("blank", link.blank, monE.blank);
                end
                if (link.frame_valid === 1'b1) lastValidCycle = cycle;
            end
            if (link.scan_done === 1'b1) begin
                scanSeen++;
                if (scanQ.size() == 0) begin
                    compared++; mismatched++;
                    $display("[TB] FAIL unexpected_scan_done: got 1, expected 0");
                end else begin
                    void'(scanQ.pop_front());
                    checkOutput("scan_done_delay", cycle - lastValidCycle, 1);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit [7:0] v;
        bit [3:0] s;
        int       kind, nb, scanBefore;

        rst_n = 1'b0;
        link.ser_clk = 1'b0; link.ser_data = 1'b0; link.dig_sel = 4'b0000;
        tick(3);
        doReset();

        // Basic decode, dp off, blank pattern
        applyStimulus(8'hB0, 8, 4'b0100);
        checkOutput("pos2_digit", link.digit[11:8], 4'h3);
        checkOutput("pos2_dp", link.dp[2], 1'b0);
        checkOutput("pos2_blank", link.blank[2], 1'b0);
        applyStimulus(8'h40, 8, 4'b0001);
        checkOutput("pos0_digit", link.digit[3:0], 4'h0);
        checkOutput("pos0_dp", link.dp[0], 1'b1);
        applyStimulus(8'hFF, 8, 4'b1000);
        checkOutput("pos3_blank", link.blank[3], 1'b1);
        checkOutput("pos3_digit", link.digit[15:12], 4'hF);

        // Framing errors: short, long, not one-hot
        applyStimulus(8'h79, 7, 4'b0010);
        checkOutput("short_pos1_digit", link.digit[7:4], 4'hF);
        applyStimulus(8'h79, 9, 4'b0010);
        applyStimulus(8'h24, 8, 4'b0110);

        // Scan coverage with a repeated position
        doReset();
        scanBefore = scanSeen;
        applyStimulus(8'hF9, 8, 4'b0010);
        applyStimulus(8'hA4, 8, 4'b1000);
        applyStimulus(8'hC0, 8, 4'b0001);
        applyStimulus(8'hB0, 8, 4'b1000);
        checkOutput("no_early_scan", scanSeen - scanBefore, 0);
        applyStimulus(8'h92, 8, 4'b0100);
        checkOutput("one_scan_done", scanSeen - scanBefore, 1);

        // Reset mid-frame, then a clean frame and an undecodable one
        for (int i = 0; i < 4; i++) shiftBit(1'(i));
        doReset();
        applyStimulus(8'h99, 8, 4'b0001);
        checkOutput("after_reset_digit", link.digit[3:0], 4'h4);
        applyStimulus(8'hAA, 8, 4'b0010);

        // Randomized frames
        for (int n = 0; n < 30; n++) begin
            kind = $urandom_range(0, 9);
            nb   = (kind == 0) ? 7 : (kind == 1) ? 9 : 8;
            if (kind == 2) begin
                do s = 4'($urandom_range(1, 15)); while ($countones(s) == 1);
            end else begin
                s = 4'b0001 << $urandom_range(0, 3);
            end
            v[7] = 1'($urandom_range(0, 1));
            if (kind == 3)      v = 8'($urandom);
            else if (kind == 4) v[6:0] = 7'h7F;
            else                v[6:0] = segTable[$urandom_range(0, 9)];
            applyStimulus(v, nb, s);
        end

        tick(10);
        checkOutput("exp_queue_drained", expQ.size(), 0);
        checkOutput("scan_queue_drained", scanQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
